// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl
// Game-state controller for the Flappy Bird design: WAIT / FLY / DEAD / GRACE
// sequencing, packed-BCD score with saturation, multiple lives with a
// post-hit invulnerability window, edge-detected keys and a high score that
// persists across games until reset.
//
// Ports
//   clk, rst      system clock, asynchronous active-high reset
//   frame_tick    one-cycle pulse per video frame
//   btn_start     debounced start key (level)
//   btn_flap      debounced flap key (level)
//   collide       bird overlap (level), only acted on with frame_tick
//   pipe_passed   one-cycle pulse when a pipe is cleared
//   state         0 WAIT, 1 FLY, 2 DEAD, 3 GRACE
//   score         current score, packed BCD, digit 0 in LSBs
//   high_score    best score since reset, packed BCD
//   lives         remaining lives
//   flap          one-cycle flap command to the bird physics
//   new_record    last game beat the previous high score
module flappy_game_ctrl #(
  parameter  int unsigned DIGITS       = 2,
  parameter  int unsigned LIVES        = 3,
  parameter  int unsigned GRACE_FRAMES = 60,
  localparam int unsigned LW           = $clog2(LIVES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_tick,
  input  logic                  btn_start,
  input  logic                  btn_flap,
  input  logic                  collide,
  input  logic                  pipe_passed,
  output logic [1:0]            state,
  output logic [4*DIGITS-1:0]   score,
  output logic [4*DIGITS-1:0]   high_score,
  output logic [LW-1:0]         lives,
  output logic                  flap,
  output logic                  new_record
);

  localparam int unsigned SW = 4 * DIGITS;
  localparam int unsigned GW = $clog2(GRACE_FRAMES + 1);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_FLY   = 2'd1,
    ST_DEAD  = 2'd2,
    ST_GRACE = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] score_q, score_d;
  logic [SW-1:0] high_q, high_d;
  logic [LW-1:0] lives_q, lives_d;
  logic [GW-1:0] grace_q, grace_d;
  logic          flap_q, flap_d;
  logic          new_rec_q, new_rec_d;
  logic          dead_first_q, dead_first_d;
  logic          start_prev_q, flap_prev_q;

  logic start_rise, flap_rise;

  // BCD +1 with carry ripple; an all-9s value is returned unchanged.
  function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    logic          carry;
    logic          all_nines;
    all_nines = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] != 4'd9) all_nines = 1'b0;
    end
    r     = v;
    carry = ~all_nines;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Prev registers reset to 1 so a key held through reset yields no edge.
  assign start_rise = btn_start & ~start_prev_q;
  assign flap_rise  = btn_flap  & ~flap_prev_q;

  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    high_d       = high_q;
    lives_d      = lives_q;
    grace_d      = grace_q;
    new_rec_d    = new_rec_q;
    flap_d       = 1'b0;
    dead_first_d = 1'b0;

    unique case (state_q)
      ST_WAIT: begin
        score_d = '0;
        lives_d = LW'(LIVES);
        flap_d  = flap_rise;
        if (start_rise || flap_rise) state_d = ST_FLY;
      end

      ST_FLY, ST_GRACE: begin
        flap_d = flap_rise;
        if (pipe_passed) score_d = bcd_inc(score_q);
        if (state_q == ST_FLY) begin
          if (collide && frame_tick) begin
            lives_d = lives_q - LW'(1);
            if (lives_q <= LW'(1)) begin
              state_d      = ST_DEAD;
              dead_first_d = 1'b1;
            end else begin
              state_d = ST_GRACE;
              grace_d = GW'(GRACE_FRAMES);
            end
          end
        end else if (frame_tick) begin
          grace_d = grace_q - GW'(1);
          if (grace_q <= GW'(1)) begin
            grace_d = '0;
            state_d = ST_FLY;
          end
        end
      end

      ST_DEAD: begin
        // Packed BCD digits are 0-9 with the most significant digit on top,
        // so a plain unsigned compare orders BCD magnitudes correctly.
        if (dead_first_q && (score_q > high_q)) begin
          high_d    = score_q;
          new_rec_d = 1'b1;
        end
        if (start_rise) begin
          state_d   = ST_WAIT;
          score_d   = '0;
          new_rec_d = 1'b0;
          lives_d   = LW'(LIVES);
        end
      end

      default: state_d = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_WAIT;
      score_q      <= '0;
      high_q       <= '0;
      lives_q      <= LW'(LIVES);
      grace_q      <= '0;
      flap_q       <= 1'b0;
      new_rec_q    <= 1'b0;
      dead_first_q <= 1'b0;
      start_prev_q <= 1'b1;
      flap_prev_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      high_q       <= high_d;
      lives_q      <= lives_d;
      grace_q      <= grace_d;
      flap_q       <= flap_d;
      new_rec_q    <= new_rec_d;
      dead_first_q <= dead_first_d;
      start_prev_q <= btn_start;
      flap_prev_q  <= btn_flap;
    end
  end

  assign state      = state_q;
  assign score      = score_q;
  assign high_score = high_q;
  assign lives      = lives_q;
  assign flap       = flap_q;
  assign new_record = new_rec_q;

endmodule
